// File: rtl/ssm_tile_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ssm_tile_sequencer
// Description : Upstream feeder for the SSM block top. Walks every (h,p)
//               pair with h outer and p inner. For each pair it streams
//               TILES = N_TOTAL/N_TILE state tiles (B, C, h_prev slices plus
//               the per-pair scalars dt, dA, D, x) over a valid/ready link.
//               Operands come from external synchronous-read memories with
//               a 1-cycle read latency. Credit-limited issue into a 2-entry
//               output FIFO keeps at most two beats outstanding. A tag
//               (h*P+p) is emitted when a pair's last tile is accepted.
// Optional    : `define SEQ_STALL_CNT_EN builds a 32-bit saturating
//               backpressure counter on stall_cnt_o. Otherwise stall_cnt_o
//               is tied to 0.
// Ports       : clk, rstn (async, active-low)
//               start_i / busy_o / done_o          - scan control
//               rd_en_o, *_addr_o, *_rd_i          - operand memory side
//               tile_valid_o / tile_ready_i        - beat handshake
//               dt_o, dA_o, D_o, x_o, *_tile_o     - beat payload
//               tile_last_o                        - last tile of a pair
//               hp_tag_o / hp_tag_valid_o          - pair-complete tag
//               stall_cnt_o                        - backpressure counter
// Revision    : 1.0 - initial release
// ============================================================================
module ssm_tile_sequencer #(
  parameter  int DW      = 16,
  parameter  int N_TILE  = 16,
  parameter  int N_TOTAL = 128,
  parameter  int H       = 24,
  parameter  int P       = 64,
  localparam int TILES   = N_TOTAL / N_TILE,
  localparam int HW      = $clog2(H),
  localparam int HPW     = $clog2(H * P),
  localparam int TW      = (TILES > 1) ? $clog2(TILES) : 1,
  localparam int TDW     = N_TILE * DW
) (
  input  logic               clk,
  input  logic               rstn,
  // scan control
  input  logic               start_i,
  output logic               busy_o,
  output logic               done_o,
  // operand memories
  output logic               rd_en_o,
  output logic [HW-1:0]      h_addr_o,
  output logic [HPW-1:0]     hp_addr_o,
  output logic [TW-1:0]      t_addr_o,
  output logic [HPW+TW-1:0]  hprev_addr_o,
  input  logic [DW-1:0]      dt_rd_i,
  input  logic [DW-1:0]      dA_rd_i,
  input  logic [DW-1:0]      D_rd_i,
  input  logic [DW-1:0]      x_rd_i,
  input  logic [TDW-1:0]     B_rd_i,
  input  logic [TDW-1:0]     C_rd_i,
  input  logic [TDW-1:0]     hprev_rd_i,
  // beat stream
  output logic               tile_valid_o,
  input  logic               tile_ready_i,
  output logic [DW-1:0]      dt_o,
  output logic [DW-1:0]      dA_o,
  output logic [DW-1:0]      D_o,
  output logic [DW-1:0]      x_o,
  output logic [TDW-1:0]     B_tile_o,
  output logic [TDW-1:0]     C_tile_o,
  output logic [TDW-1:0]     hprev_tile_o,
  output logic               tile_last_o,
  // pair completion tag
  output logic [HPW-1:0]     hp_tag_o,
  output logic               hp_tag_valid_o,
  // backpressure statistics
  output logic [31:0]        stall_cnt_o
);

  localparam int PW = (P > 1) ? $clog2(P) : 1;
  localparam int AW = HPW + TW;

  // One buffered beat: payload plus the bookkeeping that travels with it.
  typedef struct packed {
    logic [DW-1:0]  dt;
    logic [DW-1:0]  da;
    logic [DW-1:0]  d;
    logic [DW-1:0]  x;
    logic [TDW-1:0] b;
    logic [TDW-1:0] c;
    logic [TDW-1:0] hprev;
    logic           last;
    logic [HPW-1:0] tag;
  } beat_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t         state;
  logic [HW-1:0]  h_cnt;
  logic [PW-1:0]  p_cnt;
  logic [TW-1:0]  t_cnt;
  logic           busy;
  logic           done;

  // Read issued last cycle; its data is on the *_rd_i inputs this cycle.
  logic           inflight;
  logic           inflight_last;
  logic [HPW-1:0] inflight_tag;

  // Two-entry FIFO: head drives the outputs, skid absorbs the read that
  // was already in flight when backpressure appeared.
  beat_t          head;
  beat_t          skid;
  beat_t          in_beat;
  logic [1:0]     fifo_cnt;

  logic           tag_valid;
  logic [HPW-1:0] tag_q;

  logic           head_vld;
  logic           pop;
  logic           push;
  logic [1:0]     occupied;
  logic           credit;
  logic           issue;
  logic           last_t;
  logic           last_p;
  logic           last_h;
  logic [HPW-1:0] hp_idx;
  logic [AW-1:0]  hprev_idx;
  logic           final_pop;

  // --------------------------------------------------------------------------
  // Address generation and issue credit
  // --------------------------------------------------------------------------
  assign last_t    = (t_cnt == TW'(TILES - 1));
  assign last_p    = (p_cnt == PW'(P - 1));
  assign last_h    = (h_cnt == HW'(H - 1));
  assign hp_idx    = HPW'(h_cnt) * HPW'(P) + HPW'(p_cnt);
  assign hprev_idx = AW'(hp_idx) * AW'(TILES) + AW'(t_cnt);

  assign head_vld  = (fifo_cnt != 2'd0);
  assign pop       = head_vld && tile_ready_i;
  assign push      = inflight;

  // A beat accepted this cycle frees its slot immediately, so a steady
  // ready stream sustains one read per cycle. inflight + fifo_cnt never
  // exceeds 2, and pop implies fifo_cnt >= 1, so this cannot underflow.
  assign occupied  = fifo_cnt + {1'b0, inflight} - {1'b0, pop};
  assign credit    = (occupied < 2'd2);
  assign issue     = (state == ST_RUN) && credit;

  // The very last beat of the scan is the one carrying the final tag.
  assign final_pop = pop && head.last && (head.tag == HPW'(H * P - 1));

  assign rd_en_o      = issue;
  assign h_addr_o     = h_cnt;
  assign hp_addr_o    = hp_idx;
  assign t_addr_o     = t_cnt;
  assign hprev_addr_o = hprev_idx;

  // --------------------------------------------------------------------------
  // Scan FSM and (h,p,t) counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
      h_cnt <= '0;
      p_cnt <= '0;
      t_cnt <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            state <= ST_RUN;
            busy  <= 1'b1;
            h_cnt <= '0;
            p_cnt <= '0;
            t_cnt <= '0;
          end
        end
        ST_RUN: begin
          if (issue) begin
            if (last_t) begin
              t_cnt <= '0;
              if (last_p) begin
                p_cnt <= '0;
                if (last_h) begin
                  h_cnt <= '0;
                  state <= ST_DRAIN;
                end else begin
                  h_cnt <= h_cnt + HW'(1);
                end
              end else begin
                p_cnt <= p_cnt + PW'(1);
              end
            end else begin
              t_cnt <= t_cnt + TW'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (final_pop) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // In-flight read bookkeeping: last flag and tag follow the read by one
  // cycle so they line up with the memory data.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      inflight_tag  <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_last <= last_t;
        inflight_tag  <= hp_idx;
      end
    end
  end

  assign in_beat = {dt_rd_i, dA_rd_i, D_rd_i, x_rd_i,
                    B_rd_i, C_rd_i, hprev_rd_i,
                    inflight_last, inflight_tag};

  // --------------------------------------------------------------------------
  // Output FIFO (head + skid). Push without pop at full occupancy cannot
  // happen because issue is credit-limited.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head     <= '0;
      skid     <= '0;
      fifo_cnt <= 2'd0;
    end else begin
      case (fifo_cnt)
        2'd0: begin
          if (push) begin
            head     <= in_beat;
            fifo_cnt <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head <= in_beat;
          end else if (push) begin
            skid     <= in_beat;
            fifo_cnt <= 2'd2;
          end else if (pop) begin
            fifo_cnt <= 2'd0;
          end
        end
        2'd2: begin
          if (pop) begin
            head <= skid;
            if (push) begin
              skid <= in_beat;
            end else begin
              fifo_cnt <= 2'd1;
            end
          end
        end
        default: fifo_cnt <= 2'd0;
      endcase
    end
  end

  assign tile_valid_o = head_vld;
  assign dt_o         = head.dt;
  assign dA_o         = head.da;
  assign D_o          = head.d;
  assign x_o          = head.x;
  assign B_tile_o     = head.b;
  assign C_tile_o     = head.c;
  assign hprev_tile_o = head.hprev;
  assign tile_last_o  = head.last;

  // --------------------------------------------------------------------------
  // Pair-complete tag, one cycle after the last tile's handshake
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tag_valid <= 1'b0;
      tag_q     <= '0;
    end else begin
      tag_valid <= pop && head.last;
      if (pop && head.last) begin
        tag_q <= head.tag;
      end
    end
  end

  assign hp_tag_valid_o = tag_valid;
  assign hp_tag_o       = tag_q;
  assign busy_o         = busy;
  assign done_o         = done;

  // --------------------------------------------------------------------------
  // Optional backpressure counter
  // --------------------------------------------------------------------------
`ifdef SEQ_STALL_CNT_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt <= 32'd0;
    end else if ((state == ST_IDLE) && start_i) begin
      stall_cnt <= 32'd0;
    end else if (head_vld && !tile_ready_i && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt;
`else
  assign stall_cnt_o = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ssm_tile_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ssm_tile_sequencer
// Description : Directed self-checking bench for ssm_tile_sequencer. A small
//               instance (H=2, P=3, TILES=4) covers streaming, random and
//               directed backpressure, restart-while-busy and mid-scan reset.
//               A default-parameter instance covers a full-size scan.
//               Memories return address-encoded data; expected beats are
//               derived from the beat index alone.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ssm_tile_sequencer;

  localparam int DW  = 16;
  localparam int NT  = 16;
  localparam int TDW = NT * DW;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------------------------------------------------------- small DUT
  logic           start, busy, done, rd_en, ready, valid, last, tag_valid;
  logic [0:0]     h_addr;
  logic [2:0]     hp_addr;
  logic [1:0]     t_addr;
  logic [4:0]     hprev_addr;
  logic [2:0]     tag;
  logic [31:0]    stall_cnt;
  logic [DW-1:0]  dt_rd, da_rd, d_rd, x_rd, dt, da, d, x;
  logic [TDW-1:0] b_rd, c_rd, hp_rd, b_t, c_t, hp_t;

  ssm_tile_sequencer #(.DW(DW), .N_TILE(NT), .N_TOTAL(64), .H(2), .P(3)) dut (
    .clk(clk), .rstn(rstn), .start_i(start), .busy_o(busy), .done_o(done),
    .rd_en_o(rd_en), .h_addr_o(h_addr), .hp_addr_o(hp_addr), .t_addr_o(t_addr),
    .hprev_addr_o(hprev_addr), .dt_rd_i(dt_rd), .dA_rd_i(da_rd), .D_rd_i(d_rd),
    .x_rd_i(x_rd), .B_rd_i(b_rd), .C_rd_i(c_rd), .hprev_rd_i(hp_rd),
    .tile_valid_o(valid), .tile_ready_i(ready), .dt_o(dt), .dA_o(da), .D_o(d),
    .x_o(x), .B_tile_o(b_t), .C_tile_o(c_t), .hprev_tile_o(hp_t),
    .tile_last_o(last), .hp_tag_o(tag), .hp_tag_valid_o(tag_valid),
    .stall_cnt_o(stall_cnt));

  function automatic logic [TDW-1:0] tile_pat(input int base, input int a);
    logic [TDW-1:0] r;
    for (int j = 0; j < NT; j++) r[16*j +: 16] = 16'(base * 4096 + a * 16 + j);
    return r;
  endfunction

  always @(posedge clk) begin
    if (rd_en) begin
      dt_rd <= 16'h1000 + 16'(h_addr);
      da_rd <= 16'h2000 + 16'(h_addr);
      d_rd  <= 16'h3000 + 16'(h_addr);
      x_rd  <= 16'h4000 + 16'(hp_addr);
      b_rd  <= tile_pat(5, int'(t_addr));
      c_rd  <= tile_pat(6, int'(t_addr));
      hp_rd <= tile_pat(7, int'(hprev_addr));
    end
  end

  // -------------------------------------------------------------- default DUT
  logic           b_start, b_busy, b_done, b_rd_en, b_ready, b_valid, b_last, b_tag_valid;
  logic [4:0]     b_h_addr;
  logic [10:0]    b_hp_addr;
  logic [2:0]     b_t_addr;
  logic [13:0]    b_hprev_addr;
  logic [10:0]    b_tag;
  logic [31:0]    b_stall;
  logic [DW-1:0]  b_dt_rd, b_da_rd, b_d_rd, b_x_rd, b_dt, b_da, b_d, b_x;
  logic [TDW-1:0] b_b_rd, b_c_rd, b_hp_rd, b_b_t, b_c_t, b_hp_t;

  ssm_tile_sequencer dut_big (
    .clk(clk), .rstn(rstn), .start_i(b_start), .busy_o(b_busy), .done_o(b_done),
    .rd_en_o(b_rd_en), .h_addr_o(b_h_addr), .hp_addr_o(b_hp_addr), .t_addr_o(b_t_addr),
    .hprev_addr_o(b_hprev_addr), .dt_rd_i(b_dt_rd), .dA_rd_i(b_da_rd), .D_rd_i(b_d_rd),
    .x_rd_i(b_x_rd), .B_rd_i(b_b_rd), .C_rd_i(b_c_rd), .hprev_rd_i(b_hp_rd),
    .tile_valid_o(b_valid), .tile_ready_i(b_ready), .dt_o(b_dt), .dA_o(b_da), .D_o(b_d),
    .x_o(b_x), .B_tile_o(b_b_t), .C_tile_o(b_c_t), .hprev_tile_o(b_hp_t),
    .tile_last_o(b_last), .hp_tag_o(b_tag), .hp_tag_valid_o(b_tag_valid),
    .stall_cnt_o(b_stall));

  always @(posedge clk) begin
    if (b_rd_en) begin
      b_dt_rd <= 16'(b_h_addr);
      b_da_rd <= 16'(b_h_addr) + 16'd1;
      b_d_rd  <= 16'(b_h_addr) + 16'd2;
      b_x_rd  <= 16'(b_hp_addr);
      b_b_rd  <= {NT{16'(b_t_addr)}};
      b_c_rd  <= {NT{16'(b_t_addr) + 16'h0100}};
      b_hp_rd <= {NT{16'(b_hprev_addr)}};
    end
  end

  // ------------------------------------------------------------------ checker
  task automatic check_eq(input string name, input logic [255:0] got, input logic [255:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // ---------------------------------------------------------- monitor state
  int mode = 0;
  int start_req = 0;
  int cyc = 0;
  int beat_cnt = 0, tag_cnt = 0, done_cnt = 0;
  int issued = 0, accepted = 0;
  int first_hs = -1, last_hs = -1;
  int stall_started = 0, stall_left = 0, stall_idx = 0;
  int rd_in_stall = 0, resume_beat = -1;
  logic prev_stall = 1'b0, prev_hs_last = 1'b0;
  logic [TDW-1:0] sv_b, sv_c, sv_hp;
  logic [64:0]    sv_scal;

  task automatic reset_checks();
    check_eq("rst_ctrl", 256'({busy, done, rd_en, valid, tag_valid, last}), 256'(0));
    check_eq("rst_addr", 256'({h_addr, hp_addr, t_addr, hprev_addr, tag}), 256'(0));
    check_eq("rst_stall_cnt", 256'(stall_cnt), 256'(0));
    check_eq("rst_scalars", 256'({dt, da, d, x}), 256'(0));
    check_eq("rst_B", 256'(b_t), 256'(0));
    check_eq("rst_C", 256'(c_t), 256'(0));
    check_eq("rst_hprev", 256'(hp_t), 256'(0));
  endtask

  task automatic monitor();
    int k, hh, pp, tt, hp;
    logic hs;
    cyc++;
    if (!rstn) begin
      prev_stall   = 1'b0;
      prev_hs_last = 1'b0;
      return;
    end
    if (start && !busy) begin
      beat_cnt = 0; tag_cnt = 0; done_cnt = 0;
      issued = 0; accepted = 0; first_hs = -1; last_hs = -1;
    end
    if (prev_stall) begin
      check_eq("stall_valid", 256'(valid), 256'(1));
      check_eq("stall_B", 256'(b_t), 256'(sv_b));
      check_eq("stall_C", 256'(c_t), 256'(sv_c));
      check_eq("stall_hprev", 256'(hp_t), 256'(sv_hp));
      check_eq("stall_scalars", 256'({dt, da, d, x, last}), 256'(sv_scal));
    end
    if (tag_valid) begin
      check_eq("tag_order", 256'(tag), 256'(tag_cnt));
      check_eq("tag_after_last", 256'(prev_hs_last), 256'(1));
      tag_cnt++;
    end
    if (done) begin
      check_eq("done_busy_low", 256'(busy), 256'(0));
      check_eq("done_after_last", 256'(last_hs == cyc - 1), 256'(1));
      done_cnt++;
    end
    hs = valid && ready;
    prev_hs_last = hs && last;
    if (hs) begin
      k  = beat_cnt;
      hh = k / 12;
      pp = (k / 4) % 3;
      tt = k % 4;
      hp = hh * 3 + pp;
      if (k >= 24) check_eq("beat_count_limit", 256'(k), 256'(23));
      check_eq("beat_B", 256'(b_t), 256'(tile_pat(5, tt)));
      check_eq("beat_C", 256'(c_t), 256'(tile_pat(6, tt)));
      check_eq("beat_hprev", 256'(hp_t), 256'(tile_pat(7, hp * 4 + tt)));
      check_eq("beat_scalars", 256'({dt, da, d, x, last}),
               256'({16'(16'h1000 + hh), 16'(16'h2000 + hh), 16'(16'h3000 + hh),
                     16'(16'h4000 + hp), 1'(tt == 3)}));
      if (first_hs < 0) first_hs = cyc;
      last_hs = cyc;
      beat_cnt++;
      accepted++;
    end
    issued += int'(rd_en);
    check_eq("outstanding_le2", 256'((issued - accepted) <= 2), 256'(1));
    prev_stall = valid && !ready;
    sv_b    = b_t;
    sv_c    = c_t;
    sv_hp   = hp_t;
    sv_scal = {dt, da, d, x, last};
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later
  // with the inputs the next rising edge will see.
  task automatic cycle();
    @(negedge clk);
    start     = (start_req != 0);
    start_req = 0;
    case (mode)
      1: ready = ($urandom_range(0, 9) < 3);
      2: begin
        if (stall_started == 0 && valid && beat_cnt == 18) begin
          stall_started = 1;
          stall_left    = 10;
          stall_idx     = 0;
        end
        if (stall_left > 0) begin
          ready = 1'b0;
          stall_left--;
          stall_idx++;
          if (stall_left == 0) resume_beat = beat_cnt;
        end else begin
          ready = 1'b1;
        end
      end
      default: ready = 1'b1;
    endcase
    #1;
    if (mode == 2 && !ready && stall_idx >= 3) rd_in_stall += int'(rd_en);
    monitor();
  endtask

  task automatic wait_done(input int max_cyc);
    for (int i = 0; i < max_cyc && done_cnt == 0; i++) cycle();
    if (done_cnt == 0) check_eq("done_timeout", 256'(0), 256'(1));
  endtask

  // ------------------------------------------------------------------ stimulus
  initial begin
    int bk, btag, blast, bdone, bh, bhp, bt;
    rstn = 1'b0; start = 1'b0; ready = 1'b1;
    b_start = 1'b0; b_ready = 1'b1;

    repeat (3) @(negedge clk);
    #1 reset_checks();
    @(negedge clk);
    rstn = 1'b1;
    cycle(); cycle();

    // Streaming with ready held high, plus a start pulse while busy.
    start_req = 1; cycle();
    cycle();
    check_eq("lat_busy", 256'(busy), 256'(1));
    check_eq("lat_rd_en", 256'(rd_en), 256'(1));
    check_eq("lat_valid_c1", 256'(valid), 256'(0));
    cycle();
    check_eq("lat_valid_c2", 256'(valid), 256'(0));
    cycle();
    check_eq("lat_valid_c3", 256'(valid), 256'(1));
    repeat (5) cycle();
    start_req = 1; cycle();
    wait_done(200);
    check_eq("A_beats", 256'(beat_cnt), 256'(24));
    check_eq("A_tags", 256'(tag_cnt), 256'(6));
    check_eq("A_back_to_back", 256'(last_hs - first_hs), 256'(23));
    check_eq("A_stall_cnt", 256'(stall_cnt), 256'(0));
    repeat (10) cycle();
    check_eq("A_beats_after", 256'(beat_cnt), 256'(24));
    check_eq("A_done_once", 256'(done_cnt), 256'(1));
    check_eq("A_idle", 256'(busy), 256'(0));

    // Random 30 % ready.
    mode = 1;
    start_req = 1; cycle();
    wait_done(2000);
    check_eq("B_beats", 256'(beat_cnt), 256'(24));
    check_eq("B_tags", 256'(tag_cnt), 256'(6));
    check_eq("B_done_once", 256'(done_cnt), 256'(1));
    mode = 0; cycle();

    // Ten-cycle stall with (h=1,p=1,t=2) at the head.
    mode = 2; stall_started = 0; rd_in_stall = 0;
    start_req = 1; cycle();
    wait_done(300);
    check_eq("C_stall_hit", 256'(stall_started), 256'(1));
    check_eq("C_resume_beat", 256'(resume_beat), 256'(18));
    check_eq("C_rd_during_stall", 256'(rd_in_stall), 256'(0));
    check_eq("C_beats", 256'(beat_cnt), 256'(24));
    check_eq("C_tags", 256'(tag_cnt), 256'(6));
`ifdef SEQ_STALL_CNT_EN
    check_eq("C_stall_cnt", 256'(stall_cnt), 256'(10));
`else
    check_eq("C_stall_cnt", 256'(stall_cnt), 256'(0));
`endif
    mode = 0; cycle();

    // Reset in the middle of a scan, then a fresh scan.
    start_req = 1; cycle();
    repeat (12) cycle();
    rstn = 1'b0;
    #1 reset_checks();
    repeat (3) cycle();
    rstn = 1'b1;
    cycle();
    start_req = 1; cycle();
    wait_done(200);
    check_eq("D_beats", 256'(beat_cnt), 256'(24));
    check_eq("D_tags", 256'(tag_cnt), 256'(6));
    check_eq("D_done_once", 256'(done_cnt), 256'(1));

    // Default-parameter full scan.
    bk = 0; btag = 0; blast = -1; bdone = 0;
    @(negedge clk);
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    for (int c = 0; c < 14000 && bdone == 0; c++) begin
      @(negedge clk);
      #1;
      if (b_tag_valid) begin
        check_eq("big_tag_order", 256'(b_tag), 256'(btag));
        btag++;
      end
      if (b_done) begin
        check_eq("big_done_after_last", 256'(blast == c - 1), 256'(1));
        check_eq("big_done_busy_low", 256'(b_busy), 256'(0));
        bdone = 1;
      end
      if (b_valid && b_ready) begin
        bh  = bk / 512;
        bhp = bk / 8;
        bt  = bk % 8;
        check_eq("big_scalars", 256'({b_dt, b_da, b_d, b_x, b_last}),
                 256'({16'(bh), 16'(bh + 1), 16'(bh + 2), 16'(bhp), 1'(bt == 7)}));
        check_eq("big_B", 256'(b_b_t), 256'({NT{16'(bt)}}));
        check_eq("big_C", 256'(b_c_t), 256'({NT{16'(bt + 256)}}));
        check_eq("big_hprev", 256'(b_hp_t), 256'({NT{16'(bk)}}));
        blast = c;
        bk++;
      end
    end
    check_eq("big_done_seen", 256'(bdone), 256'(1));
    check_eq("big_beats", 256'(bk), 256'(12288));
    check_eq("big_tags", 256'(btag), 256'(1536));
    check_eq("big_stall_cnt", 256'(b_stall), 256'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ssm_tile_sequencer.md
Name: ssm_tile_sequencer

Overview:
- Upstream feeder for the SSM block top.
- Walks every (h,p) pair in h-outer, p-inner order. For each pair, streams N_TOTAL/N_TILE state tiles (B, C, h_prev slices plus the per-(h,p) scalars dt, dA, D, x) over a valid/ready link.
- Fetches operands from external synchronous-read memories with 1-cycle read latency.
- Emits an (h*P+p) tag when a pair's last tile is accepted, so the downstream y collector can place y_final results.

Parameters:
- DW, 16, operand width (FP16 bit patterns; never interpreted).
- N_TILE, 16, lanes per tile.
- N_TOTAL, 128, state dimension N; must be a multiple of N_TILE.
- H, 24, number of heads.
- P, 64, head dimension.
- Derived, not overridable: TILES=N_TOTAL/N_TILE; HW=$clog2(H); HPW=$clog2(H*P); TW=max(1,$clog2(TILES)).

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- start_i  in  1  one-cycle start pulse for a full scan.
- busy_o  out  1  high from the cycle after an accepted start until done.
- done_o  out  1  one-cycle pulse at the end of a scan.
- rd_en_o  out  1  read strobe to all operand memories.
- h_addr_o  out  HW  address for the dt/dA/D memories.
- hp_addr_o  out  HPW  address for the x memory (h*P+p).
- t_addr_o  out  TW  tile address for the B/C memories.
- hprev_addr_o  out  HPW+TW  address for the h_prev memory ((h*P+p)*TILES+t).
- dt_rd_i, dA_rd_i, D_rd_i, x_rd_i  in  DW each  scalar read data; valid 1 cycle after rd_en_o.
- B_rd_i, C_rd_i, hprev_rd_i  in  N_TILE*DW each  tile read data; valid 1 cycle after rd_en_o.
- tile_valid_o  out  1  tile beat valid.
- tile_ready_i  in  1  downstream ready.
- dt_o, dA_o, D_o, x_o  out  DW each  scalars carried with every beat.
- B_tile_o, C_tile_o, hprev_tile_o  out  N_TILE*DW each  tile payload; lane j occupies bits [DW*j +: DW].
- tile_last_o  out  1  beat is tile TILES-1 of its (h,p).
- hp_tag_o  out  HPW  h*P+p of the pair just completed.
- hp_tag_valid_o  out  1  one-cycle tag strobe.
- stall_cnt_o  out  32  backpressure counter (see Optional Feature).

Behaviour:
- Reset: rstn is asynchronous and active-low; the clock is clk. While rstn is low, every output and all internal state are 0, including counters h/p/t, the buffer and in-flight flags. Reads in flight at reset are discarded. After release the block sits in IDLE.
- FSM states:
  - IDLE: start_i moves to RUN; busy_o goes high the next cycle.
  - RUN: issue reads and stream beats.
  - DRAIN: all reads issued; wait for the buffer to empty and the last beat to be accepted.
  - IDLE again: done_o pulses for one cycle and busy_o drops in that same cycle.
- start_i is ignored outside IDLE.
- Issue order: the counter t increments fastest, wrapping at TILES-1, then p (wraps at P-1), then h.
  - A read is issued (rd_en_o=1 with all addresses from the current counters) only when credit allows.
  - Credit: in-flight reads + occupied buffer entries < 2, evaluated against the same cycle's handshake. An accepted beat frees a slot in the same cycle.
  - After the read for (H-1,P-1,TILES-1) is issued, the FSM goes to DRAIN and rd_en_o stays 0.
- Read data is captured 1 cycle after issue into a 2-entry FIFO (output register plus skid register). The tile_last flag and tag travel alongside the data.
- Output side:
  - tile_valid_o equals "FIFO head occupied".
  - While tile_valid_o=1 and tile_ready_i=0, all payload outputs hold stable.
  - Handshake occurs when tile_valid_o and tile_ready_i are both high.
  - With tile_ready_i held high, throughput is 1 beat/cycle after an initial 2-cycle latency: start to first tile_valid_o is 2 cycles after entering RUN.
- Tags: hp_tag_valid_o pulses in the cycle after a handshake on a beat with tile_last_o=1, with hp_tag_o set to that beat's h*P+p. Exactly H*P tags per scan, in ascending order.
- done_o pulses the cycle after the final beat's handshake, which coincides with the final tag pulse.
- Address widths truncate naturally; with the parameter constraints, counters never exceed their ranges.
- tile_ready_i high while tile_valid_o=0 has no effect.
- A FIFO push and pop in the same cycle keeps occupancy unchanged.

Optional Feature:
- Macro SEQ_STALL_CNT_EN.
- When defined: stall_cnt_o is a 32-bit saturating counter.
  - Clears on start acceptance.
  - Increments each cycle where tile_valid_o=1 and tile_ready_i=0.
  - Holds its value after done.
- When undefined: stall_cnt_o is tied to 0 and no counter logic is built.

Test Plan:
- Config H=2, P=3, N_TOTAL=64, N_TILE=16 (TILES=4), tile_ready_i held 1, memories filled with address-encoded data. Required response:
  - 24 consecutive beats, lane payloads matching the addresses.
  - tile_last_o on beats 3, 7, ... 23.
  - Tags 0..5 in order.
  - done_o exactly once, 1 cycle after beat 23; busy_o deasserts in that same cycle.
- Random tile_ready_i at 30% duty. Required response:
  - Payload stays stable during every stall.
  - No beat lost or duplicated: 24 beats in order.
  - Never more than 2 reads outstanding plus buffered.
- tile_ready_i low for 10 cycles mid-pair (h=1, p=1, t=2). Required response:
  - rd_en_o stops after the buffer fills.
  - The stream resumes at t=2 with the correct payload.
  - With SEQ_STALL_CNT_EN defined, stall_cnt_o = 10.
- start_i pulsed again while busy. Required response: ignored, and the beat count stays 24.
- rstn asserted mid-scan, then a new start. Required response:
  - All outputs are 0 during reset.
  - After restart, the first beat is (h=0, p=0, t=0) and no stale data appears.
- Default parameters (H=24, P=64, TILES=8), ready always high. Required response: 12288 beats, 1536 tags, done_o after the last beat, stall_cnt_o=0.
